// File: rtl/spi_matrix_tx.sv
// SPI mode-0 master that shifts one {y_matrix, x_matrix} LED frame to the display board.
// load frames the whole transfer; sdi changes only on the clk edge where sck falls.
module spi_matrix_tx #(
  parameter int FRAME_BITS = 144,
  parameter int CLK_DIV    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [71:0] x_matrix,
  input  logic [71:0] y_matrix,
  output logic        sck,
  output logic        sdi,
  output logic        load,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    SCK_LO,
    SCK_HI,
    TAIL,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] BIT_LAST = 8'(FRAME_BITS - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_div;
  logic [7:0]            w_div_next;
  logic [7:0]            r_bitcnt;
  logic [7:0]            w_bitcnt_next;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [FRAME_BITS-1:0] w_shreg_next;
  logic                  w_div_last;
  logic                  w_in_frame;
  logic                  w_clocking;

  logic r_sck;
  logic r_sdi;
  logic r_load;
  logic r_done;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_bitcnt_next = r_bitcnt;
    w_shreg_next  = r_shreg;
    w_div_last    = (r_div == DIV_LAST);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_shreg_next  = {y_matrix, x_matrix};
          w_bitcnt_next = 8'd0;
          w_div_next    = 8'd0;
          w_state_next  = SCK_LO;
        end
      end
      SCK_LO: begin
        if (w_div_last) begin
          w_div_next   = 8'd0;
          w_state_next = SCK_HI;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      SCK_HI: begin
        if (w_div_last) begin
          // Shifting on the falling sck edge keeps sdi stable for the whole high phase.
          w_div_next    = 8'd0;
          w_shreg_next  = {r_shreg[FRAME_BITS-2:0], 1'b0};
          w_bitcnt_next = r_bitcnt + 8'd1;
          w_state_next  = (r_bitcnt == BIT_LAST) ? TAIL : SCK_LO;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      TAIL: begin
        if (w_div_last) begin
          w_div_next   = 8'd0;
          w_state_next = DONE;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_clocking = (w_state_next == SCK_LO) || (w_state_next == SCK_HI);
    w_in_frame = w_clocking || (w_state_next == TAIL);
  end

  // Pins are registered from the next state so sck/load/sdi leave the block glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments; the shift register is reset too so an aborted frame leaves sdi low.
      r_state  <= IDLE;
      r_div    <= 8'd0;
      r_bitcnt <= 8'd0;
      r_shreg  <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
      r_load   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_bitcnt <= w_bitcnt_next;
      r_shreg  <= w_shreg_next;
      r_sck    <= (w_state_next == SCK_HI);
      r_sdi    <= w_clocking ? w_shreg_next[FRAME_BITS-1] : 1'b0;
      r_load   <= w_in_frame;
      r_done   <= (w_state_next == DONE);
    end
  end

  assign sck  = r_sck;
  assign sdi  = r_sdi;
  assign load = r_load;
  assign busy = r_load;
  assign done = r_done;

endmodule

// File: tb/tb_spi_matrix_tx.sv
// Bench for spi_matrix_tx: a CLK_DIV=4 and a CLK_DIV=1 instance, each with a display
// shift-register model and a scoreboard that is checked whenever done pulses.
module tb_spi_matrix_tx;

  typedef struct packed {
    logic [71:0] y;
    logic [71:0] x;
    logic [31:0] t0;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       start_i;
  logic [1:0][71:0] xm;
  logic [1:0][71:0] ym;
  logic [1:0]       sck_o;
  logic [1:0]       sdi_o;
  logic [1:0]       load_o;
  logic [1:0]       busy_o;
  logic [1:0]       done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t q0[$];
  exp_t q1[$];

  int           rises    [2];
  int           hi_cyc   [2];
  int           load_cyc [2];
  int           busy_cyc [2];
  int           viol     [2];
  int           rise_now [2];
  int           done_cnt [2];
  logic [143:0] model      [2];
  logic [143:0] last_frame [2];
  logic [1:0]   p_sck  = '0;
  logic [1:0]   p_sdi  = '0;
  logic [1:0]   p_load = '0;
  logic [1:0]   p_done = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_matrix_tx #(.FRAME_BITS(144), .CLK_DIV(4)) u_dut4 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start_i[0]),
    .x_matrix (xm[0]),
    .y_matrix (ym[0]),
    .sck      (sck_o[0]),
    .sdi      (sdi_o[0]),
    .load     (load_o[0]),
    .busy     (busy_o[0]),
    .done     (done_o[0])
  );

  spi_matrix_tx #(.FRAME_BITS(144), .CLK_DIV(1)) u_dut1 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start_i[1]),
    .x_matrix (xm[1]),
    .y_matrix (ym[1]),
    .sck      (sck_o[1]),
    .sdi      (sdi_o[1]),
    .load     (load_o[1]),
    .busy     (busy_o[1]),
    .done     (done_o[1])
  );

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_frame(input int d);
    rises[d]    = 0;
    hi_cyc[d]   = 0;
    load_cyc[d] = 0;
    busy_cyc[d] = 0;
    viol[d]     = 0;
    rise_now[d] = -1;
    model[d]    = '0;
  endtask

  task automatic push(input int d, input logic [71:0] y, input logic [71:0] x, input int t0);
    exp_t e;
    e.y  = y;
    e.x  = x;
    e.t0 = 32'(t0);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: display-side shift register plus per-frame timing, scored at each done pulse.
  task automatic mon_step(input int d);
    exp_t e;
    bit   have;
    int   now;
    int   dv;
    int   t0;
    now = cyc + 1;
    dv  = div_of(d);
    if (!rst_n) begin
      clear_frame(d);
    end else begin
      if (sck_o[d] && !p_sck[d]) begin
        rises[d]++;
        model[d] = {model[d][142:0], sdi_o[d]};
      end
      if (sck_o[d]) hi_cyc[d]++;
      if (load_o[d] && !p_load[d]) rise_now[d] = now;
      if (load_o[d]) load_cyc[d]++;
      if (busy_o[d]) busy_cyc[d]++;
      if (load_o[d] && p_load[d] && (sdi_o[d] != p_sdi[d]) && !(p_sck[d] && !sck_o[d]))
        viol[d]++;
      if (done_o[d]) begin
        done_cnt[d]++;
        have = 1'b0;
        if (d == 0) begin
          if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
          if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
          check($sformatf("unexpected_done[%0d]", d), 144'(done_o[d]), 144'(0));
        end else begin
          t0 = int'(e.t0);
          check($sformatf("frame_bits[%0d]", d), model[d], {e.y, e.x});
          check($sformatf("sck_rises[%0d]", d), 144'(rises[d]), 144'(144));
          check($sformatf("sck_high_cycles[%0d]", d), 144'(hi_cyc[d]), 144'(144 * dv));
          check($sformatf("load_rise_cycle[%0d]", d), 144'(rise_now[d]), 144'(t0 + 1));
          check($sformatf("done_cycle[%0d]", d), 144'(now), 144'(t0 + 1 + 289 * dv));
          check($sformatf("load_cycles[%0d]", d), 144'(load_cyc[d]), 144'(289 * dv));
          check($sformatf("busy_cycles[%0d]", d), 144'(busy_cyc[d]), 144'(289 * dv));
          check($sformatf("sdi_stable_high[%0d]", d), 144'(viol[d]), 144'(0));
          check($sformatf("done_cycle_pins[%0d]", d),
                144'({sck_o[d], sdi_o[d], load_o[d], busy_o[d], p_done[d]}), 144'(0));
        end
        last_frame[d] = model[d];
        clear_frame(d);
      end
    end
    p_sck[d]  = sck_o[d];
    p_sdi[d]  = sdi_o[d];
    p_load[d] = load_o[d];
    p_done[d] = done_o[d];
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [71:0] y, input logic [71:0] x);
    @(posedge clk);
    #1;
    start_i[d] = 1'b1;
    xm[d]      = x;
    ym[d]      = y;
    @(posedge clk);
    #1;
    start_i[d] = 1'b0;
    push(d, y, x, cyc);
  endtask

  task automatic wait_done(input int d, input int target, input int limit, input string name);
    int k;
    k = 0;
    while (done_cnt[d] < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({name, "_done_seen"}, 144'(done_cnt[d] >= target), 144'(1));
  endtask

  function automatic logic [71:0] rand72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] lf;
    logic [71:0]  ya, xa, yb, xb;
    int           k;
    int           base;
    int           t0;

    rst_n   = 1'b0;
    start_i = '0;
    xm      = '0;
    ym      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins_div4", 144'({sck_o[0], sdi_o[0], load_o[0], busy_o[0], done_o[0]}), 144'(0));
    check("reset_pins_div1", 144'({sck_o[1], sdi_o[1], load_o[1], busy_o[1], done_o[1]}), 144'(0));
    rst_n = 1'b1;

    // Directed single frame, CLK_DIV=4.
    send(0, 72'h80_0000_0000_0000_0001, 72'hFF_0000_0000_0000_00AA);
    wait_done(0, 1, 1300, "frame1");
    lf = last_frame[0];
    check("first_bit", 144'(lf[143]), 144'(1));
    check("bit71", 144'(lf[72]), 144'(1));
    check("bits72_79", 144'(lf[71:64]), 144'(8'hFF));
    check("last8", 144'(lf[7:0]), 144'(8'hAA));

    // start pulse during busy is dropped.
    send(0, 72'h12_3456_789A_BCDE_F012, 72'hA5_5A5A_A5A5_0F0F_F0F0);
    wait_cyc(300);
    start_i[0] = 1'b1;
    xm[0]      = 72'hDE_ADBE_EFDE_ADBE_EF00;
    ym[0]      = 72'h01_0203_0405_0607_0809;
    wait_cyc(1);
    start_i[0] = 1'b0;
    wait_done(0, 2, 1300, "busy_start");
    wait_cyc(1300);
    check("no_extra_frame", 144'(done_cnt[0]), 144'(2));
    check("idle_after_busy_start", 144'(load_o[0]), 144'(0));

    // Reset at bit 50 aborts the frame without a done pulse.
    send(0, 72'hC3_C3C3_C3C3_C3C3_C3C3, 72'h3C_3C3C_3C3C_3C3C_3C3C);
    k = 0;
    while (rises[0] < 50 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("reached_bit50", 144'(rises[0] >= 50), 144'(1));
    rst_n = 1'b0;
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_pins", 144'({sck_o[0], load_o[0], sdi_o[0], busy_o[0], done_o[0]}), 144'(0));
    wait_cyc(1300);
    check("no_done_after_abort", 144'(done_cnt[0]), 144'(2));
    send(0, 72'h5A_0123_4567_89AB_CDEF, 72'h96_FEDC_BA98_7654_3210);
    wait_done(0, 3, 1300, "after_abort");

    // Loopback of 20 random frames, CLK_DIV=1.
    base = done_cnt[1];
    for (int i = 0; i < 20; i++) begin
      send(1, rand72(), rand72());
      wait_done(1, base + i + 1, 400, "loopback");
    end

    // start held high with matrices changed mid-frame, CLK_DIV=1.
    base = done_cnt[1];
    ya = 72'hF0_0000_0000_0000_000F;
    xa = 72'h00_FFFF_0000_FFFF_0000;
    yb = 72'h11_2233_4455_6677_8899;
    xb = 72'hAA_BBCC_DDEE_FF00_1122;
    @(posedge clk);
    #1;
    start_i[1] = 1'b1;
    xm[1]      = xa;
    ym[1]      = ya;
    @(posedge clk);
    #1;
    t0 = cyc;
    push(1, ya, xa, t0);
    push(1, yb, xb, t0 + 291);
    wait_cyc(99);
    xm[1] = xb;
    ym[1] = yb;
    wait_cyc(291);
    xm[1]      = ~xb;
    ym[1]      = ~yb;
    start_i[1] = 1'b0;
    wait_done(1, base + 2, 700, "back_to_back");
    wait_cyc(400);
    check("back_to_back_count", 144'(done_cnt[1]), 144'(base + 2));

    check("scoreboard0_drained", 144'(q0.size()), 144'(0));
    check("scoreboard1_drained", 144'(q1.size()), 144'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
